mem_access_unit: RTL and testbench

//  Multi-cycle MEM stage: replaces the single-cycle combinational memory pass-through.

---
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM stage: req/ack data-memory access with byte lanes, load extension and timeout.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: misaligned H/W/D accesses error out without touching dmem.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_rwtype,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd_addr,
  input  logic              in_reg_write,
  output logic              stall,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_data,
  output logic [4:0]        out_rd_addr,
  output logic              out_reg_write,
  output logic              out_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            r_state, w_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_we, r_uns, r_regw;
  logic [1:0]        r_size;
  logic [XLEN-1:0]   r_eaddr, r_wdata;
  logic [NB-1:0]     r_be;
  logic [4:0]        r_rd;
  logic              r_out_valid, r_out_regw, r_out_err;
  logic [XLEN-1:0]   r_out_data;
  logic [4:0]        r_out_rd;

  logic              w_mem, w_trap, w_start, w_stall, w_to, w_uns, w_sign;
  logic [1:0]        w_size;
  logic [OFFW-1:0]   w_off;
  logic [NB-1:0]     w_bemask, w_be;
  logic [XLEN-1:0]   w_wdata, w_sh, w_lmask, w_load;

  assign w_mem   = in_mem_read | in_mem_write;
  assign w_off   = in_addr[OFFW-1:0];

  // Size 0..3 = B/H/W/D; unsupported encodings fall back to signed W.
  always_comb begin
    w_size = 2'd2;
    w_uns  = 1'b0;
    case (in_rwtype)
      3'b000: w_size = 2'd0;
      3'b001: w_size = 2'd1;
      3'b011: if (XLEN == 64) w_size = 2'd3;
      3'b100: begin w_size = 2'd0; w_uns = 1'b1; end
      3'b101: begin w_size = 2'd1; w_uns = 1'b1; end
      3'b110: if (XLEN == 64) w_uns = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (w_size)
      2'd0:    w_bemask = NB'(1);
      2'd1:    w_bemask = NB'(3);
      2'd2:    w_bemask = NB'(15);
      default: w_bemask = '1;
    endcase
  end

  // Lanes past the word boundary simply shift out.
  assign w_be    = w_bemask << w_off;
  assign w_wdata = in_wdata << {w_off, 3'b000};

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign w_trap = |(w_off & OFFW'((1 << w_size) - 1));
`else
  assign w_trap = 1'b0;
`endif

  assign w_start = in_valid & w_mem & ~w_trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_stall = 1'b0;
    w_to    = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) begin w_stall = 1'b1; w_nxt = S_REQ; end
      S_REQ: begin
        if (dmem_ack) w_nxt = S_IDLE;
        else if (r_cnt == CW'(TIMEOUT - 1)) begin w_to = 1'b1; w_nxt = S_IDLE; end
        else w_stall = 1'b1;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Released on the abort cycle too, so the timed-out instruction is not reissued.
  assign stall = rst_n & w_stall;

  assign w_sh = dmem_rdata >> {r_eaddr[OFFW-1:0], 3'b000};

  always_comb begin
    w_lmask = '1;
    w_sign  = 1'b0;
    case (r_size)
      2'd0:    begin w_lmask = XLEN'(8'hFF);         w_sign = w_sh[7];  end
      2'd1:    begin w_lmask = XLEN'(16'hFFFF);      w_sign = w_sh[15]; end
      2'd2:    begin w_lmask = XLEN'(32'hFFFF_FFFF); w_sign = w_sh[31]; end
      default: ;
    endcase
    w_load = (w_sh & w_lmask) | ((w_sign & ~r_uns) ? ~w_lmask : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0; r_we <= 1'b0; r_uns <= 1'b0; r_regw <= 1'b0; r_size <= '0;
      r_eaddr <= '0; r_wdata <= '0; r_be <= '0; r_rd <= '0;
      r_out_valid <= 1'b0; r_out_regw <= 1'b0; r_out_err <= 1'b0;
      r_out_data <= '0; r_out_rd <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          if (w_start) begin
            r_cnt <= '0; r_we <= in_mem_write; r_uns <= w_uns; r_size <= w_size;
            r_regw <= in_reg_write; r_eaddr <= in_addr; r_wdata <= w_wdata;
            r_be <= w_be; r_rd <= in_rd_addr;
          end else begin
            r_out_valid <= 1'b1;
            r_out_rd    <= in_rd_addr;
            r_out_err   <= w_mem;
            r_out_regw  <= in_reg_write & ~w_mem;
            r_out_data  <= w_mem ? '0 : in_addr;
          end
        end
        S_REQ: begin
          if (dmem_ack) begin
            r_out_valid <= 1'b1; r_out_rd <= r_rd; r_out_regw <= r_regw; r_out_err <= 1'b0;
            r_out_data  <= r_we ? r_eaddr : w_load;
          end else if (w_to) begin
            r_out_valid <= 1'b1; r_out_rd <= r_rd; r_out_regw <= 1'b0; r_out_err <= 1'b1;
            r_out_data  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req      = (r_state == S_REQ);
  assign dmem_we       = r_we;
  assign dmem_addr     = {r_eaddr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign dmem_be       = r_be;
  assign dmem_wdata    = r_wdata;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_rd_addr   = r_out_rd;
  assign out_reg_write = r_out_regw;
  assign out_err       = r_out_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32, TIMEOUT=15, default build) with result scoreboard.
module tb_mem_access_unit;
  logic        clk, rst_n;
  logic        in_valid, in_mem_read, in_mem_write, in_reg_write;
  logic [2:0]  in_rwtype;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd_addr;
  logic        stall, out_valid, out_reg_write, out_err;
  logic [31:0] out_data;
  logic [4:0]  out_rd_addr;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  mem_access_unit #(.XLEN(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_rwtype(in_rwtype), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .stall(stall), .out_valid(out_valid), .out_data(out_data), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_err(out_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        rw;
    logic        er;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: out_valid must only appear when a result is pending.
  always @(negedge clk) begin
    if (q.size() == 0) chk("no_spurious_valid", {31'd0, out_valid}, 32'd0);
    else if (out_valid) begin
      exp_t e;
      e = q.pop_front();
      chk("out_data", out_data, e.d);
      chk("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, e.rd});
      chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
      chk("out_err", {31'd0, out_err}, {31'd0, e.er});
    end
  end

  task automatic alu_op(input logic [31:0] a, input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b0; in_rwtype = 3'b010;
    in_addr = a; in_rd_addr = rd; in_reg_write = rw;
    q.push_back('{d: a, rd: rd, rw: rw, er: 1'b0});
    @(negedge clk);
    chk("alu_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ackd: REQ cycle index carrying the ack (-1 = never acknowledged).
  task automatic mem_op(input logic r, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int ackd, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] edata, input logic rw, input logic eerr,
                        input int ereq, input int estall);
    int st, reqc;
    logic s, to;
    in_valid = 1'b1; in_mem_read = r; in_mem_write = w; in_rwtype = t;
    in_addr = a; in_wdata = wd; in_rd_addr = 5'd7; in_reg_write = rw;
    q.push_back('{d: edata, rd: 5'd7, rw: rw & ~eerr, er: eerr});
    st = 0; reqc = 0; to = 1'b0;
    @(negedge clk);
    chk("issue_stall", {31'd0, stall}, 32'd1);
    chk("issue_no_req", {31'd0, dmem_req}, 32'd0);
    if (stall) st++;
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      if (c == ackd) begin dmem_ack = 1'b1; dmem_rdata = rdat; end
      @(negedge clk);
      if (!dmem_req) begin to = 1'b1; break; end
      reqc++;
      s = stall;
      if (s) st++;
      if (c == 0) begin
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, w});
        chk("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
        chk("dmem_be", {28'd0, dmem_be}, {28'd0, ebe});
        if (w) chk("dmem_wdata", dmem_wdata, ewd);
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (!s) in_valid = 1'b0;
      if (c == ackd) break;
    end
    chk("req_cycles", reqc, ereq);
    chk("stall_cycles", st, estall);
    if (to) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_rwtype = 3'b000; in_addr = '0; in_wdata = '0; in_rd_addr = '0; in_reg_write = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    alu_op(32'h0000_1234, 5'd3, 1'b1);
    alu_op(32'hCAFE_0001, 5'd9, 1'b0);
    // SB 0x103, ack on the fourth REQ cycle
    mem_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB, 32'h0, 3, 4'b1000, 32'hAB00_0000,
           32'h103, 1'b0, 1'b0, 4, 4);
    mem_op(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080_0000, 0, 4'b0100, 32'h0,
           32'hFFFF_FF80, 1'b1, 1'b0, 1, 1);
    mem_op(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080_0000, 1, 4'b0100, 32'h0,
           32'h0000_0080, 1'b1, 1'b0, 2, 2);
    mem_op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h00F0_1200, 0, 4'b0110, 32'h0,
           32'hFFFF_F012, 1'b1, 1'b0, 1, 1);
    mem_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 0, 4'b1100, 32'h0,
           32'h0000_8001, 1'b1, 1'b0, 1, 1);
    mem_op(1'b0, 1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF,
           32'h200, 1'b0, 1'b0, 1, 1);
    mem_op(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000_5A5A, 32'h0, 2, 4'b1100, 32'h5A5A_0000,
           32'h302, 1'b0, 1'b0, 3, 3);
    // Misaligned W, no trap: upper lanes dropped, load upper bytes zero
    mem_op(1'b1, 1'b0, 3'b010, 32'h106, 32'h0, 32'h89AB_CDEF, 0, 4'b1100, 32'h0,
           32'h0000_89AB, 1'b1, 1'b0, 1, 1);
    // 111 and 011 behave as signed W at XLEN=32; read+write behaves as store
    mem_op(1'b1, 1'b0, 3'b111, 32'h108, 32'h0, 32'h8000_0001, 0, 4'b1111, 32'h0,
           32'h8000_0001, 1'b1, 1'b0, 1, 1);
    mem_op(1'b1, 1'b0, 3'b011, 32'h10C, 32'h0, 32'hF000_000F, 1, 4'b1111, 32'h0,
           32'hF000_000F, 1'b1, 1'b0, 2, 2);
    mem_op(1'b1, 1'b1, 3'b000, 32'h401, 32'h0000_0077, 32'h0, 0, 4'b0010, 32'h0000_7700,
           32'h401, 1'b0, 1'b0, 1, 1);
    // Timeout: LW never acknowledged
    mem_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, -1, 4'b1111, 32'h0,
           32'h0, 1'b1, 1'b1, 15, 15);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("late_ack_no_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    alu_op(32'h0000_0042, 5'd1, 1'b1);

    // Reset in the middle of a request
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_rwtype = 3'b010;
    in_addr = 32'h600; in_rd_addr = 5'd4; in_reg_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_op(1'b1, 1'b0, 3'b010, 32'h604, 32'h0, 32'h0BAD_F00D, 1, 4'b1111, 32'h0,
           32'h0BAD_F00D, 1'b1, 1'b0, 2, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
